// File: rtl/j_dsp_pkg.sv
// ---------------------------------------------------------------------------
// j_dsp_pkg
// Shared definitions for the Jerry DSP multiply-accumulate path.
//   ACC_W    accumulator width (40 bits: 32-bit word plus 8 guard bits)
//   PROD_W   multiplier product width (32 bits, signed)
//   GUARD_W  guard bits above the 32-bit word
//   state_e  MAC result-sequencing states
//   sext40() sign-extends a 32-bit product to accumulator width
// ---------------------------------------------------------------------------
package j_dsp_pkg;

    localparam int ACC_W   = 40;
    localparam int PROD_W  = 32;
    localparam int GUARD_W = ACC_W - PROD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Replicating the product sign into the guard bits keeps negative
    // products negative once they are widened to accumulator width.
    function automatic logic [ACC_W-1:0] sext40(input logic [PROD_W-1:0] p);
        return {{GUARD_W{p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/j_acc_add40.sv
// ---------------------------------------------------------------------------
// j_acc_add40
// Combinational 40-bit adder/subtractor for the MAC accumulator.
// Results wrap modulo 2^40; saturation is handled downstream.
// Ports:
//   a_i    accumulator operand
//   b_i    sign-extended product operand
//   sub_i  1 = a_i - b_i, 0 = a_i + b_i
//   y_o    result
// ---------------------------------------------------------------------------
module j_acc_add40
    import j_dsp_pkg::*;
(
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    input  logic             sub_i,
    output logic [ACC_W-1:0] y_o
);

    // Add or subtract chosen by the stage-1 sub flag.
    always_comb begin
        if (sub_i) begin
            y_o = a_i - b_i;
        end else begin
            y_o = a_i + b_i;
        end
    end

endmodule

// File: rtl/j_mac_accum.sv
// ---------------------------------------------------------------------------
// j_mac_accum
// 40-bit signed multiply-accumulate register for the Jerry DSP. Products are
// captured in stage 1, then added/subtracted into the accumulator in stage 2.
// Ports:
//   sys_clk    system clock (rising edge)
//   reset      asynchronous active-high reset
//   clr        synchronous: zero accumulator, term count, flush stage 1
//   mac_valid  product present on prod/sub
//   mac_ready  accumulator can take a product this cycle
//   prod       32-bit signed product (bit 0 = LSB)
//   sub        1 = subtract product, 0 = add
//   res_req    request: drain pipe and present result
//   res_valid  one-cycle pulse, accum_lo/accum_hi hold final sum
//   accum_lo   accumulator bits 31..0
//   accum_hi   accumulator bits 39..32 (guard bits)
//   term_cnt   products accumulated since last clr (saturates at MAXTERMS)
//   ovf_cnt    sticky: more than MAXTERMS products since clr
// ---------------------------------------------------------------------------
module j_mac_accum
    import j_dsp_pkg::*;
#(
    parameter int MAXTERMS = 16,
    parameter int CW       = 5
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               mac_valid,
    output logic               mac_ready,
    input  logic [PROD_W-1:0]  prod,
    input  logic               sub,
    input  logic               res_req,
    output logic               res_valid,
    output logic [PROD_W-1:0]  accum_lo,
    output logic [GUARD_W-1:0] accum_hi,
    output logic [CW-1:0]      term_cnt,
    output logic               ovf_cnt
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAXTERMS);

    state_e              state_q, state_d;
    logic                s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0]   s1_prod_q, s1_prod_d;
    logic                s1_sub_q, s1_sub_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CW-1:0]       term_q, term_d;
    logic                ovf_q, ovf_d;
    logic [ACC_W-1:0]    add_sum;
    logic [CW-1:0]       term_base;
    logic                accept;
    logic                done_clr;

    j_acc_add40 u_add (
        .a_i   (acc_q),
        .b_i   (sext40(s1_prod_q)),
        .sub_i (s1_sub_q),
        .y_o   (add_sum)
    );

    // Stage 1 takes whatever is accepted this cycle, so a product pending
    // there is only ever added once. clr simply skips that add, which is
    // how a pending product gets discarded while a simultaneous new one
    // still lands.
    always_comb begin
        accept     = mac_valid & mac_ready;
        s1_valid_d = accept;
        s1_prod_d  = accept ? prod : s1_prod_q;
        s1_sub_d   = accept ? sub  : s1_sub_q;

        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (s1_valid_q) begin
            acc_d = add_sum;
        end

        // A clr in the same cycle as an accept restarts the count from the
        // new product.
        term_base = clr ? '0 : term_q;
        term_d    = term_base;
        ovf_d     = clr ? 1'b0 : ovf_q;
        if (accept) begin
            if (term_base == MAX_CNT) begin
                ovf_d = 1'b1;
            end else begin
                term_d = term_base + CW'(1);
            end
        end
    end

    // Result sequencing: DRAIN waits for stage 1 to empty so the final
    // product is in the accumulator before DONE pulses it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (res_req) begin
                    state_d = accept ? DRAIN : DONE;
                end else if (accept) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (res_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_sub_q   <= 1'b0;
            acc_q      <= '0;
            term_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s1_sub_q   <= s1_sub_d;
            acc_q      <= acc_d;
            term_q     <= term_d;
            ovf_q      <= ovf_d;
        end
    end

    // A clr arriving in the DONE cycle forces the pulsed result to zero,
    // matching what the accumulator is about to become.
    always_comb begin
        mac_ready = (state_q != DRAIN) && (state_q != DONE);
        res_valid = (state_q == DONE);
        done_clr  = res_valid & clr;
        accum_lo  = done_clr ? '0 : acc_q[PROD_W-1:0];
        accum_hi  = done_clr ? '0 : acc_q[ACC_W-1:PROD_W];
        term_cnt  = term_q;
        ovf_cnt   = ovf_q;
    end

endmodule

// File: tb/tb_j_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_j_mac_accum
// Directed bench for j_mac_accum. Inputs change on the falling edge, the
// DUT updates on the rising edge, and outputs are compared on the next
// falling edge.
// ---------------------------------------------------------------------------
module tb_j_mac_accum;

    localparam int MAXTERMS = 16;
    localparam int CW       = 5;

    logic          sys_clk;
    logic          reset;
    logic          clr;
    logic          mac_valid;
    logic          mac_ready;
    logic [31:0]   prod;
    logic          sub;
    logic          res_req;
    logic          res_valid;
    logic [31:0]   accum_lo;
    logic [7:0]    accum_hi;
    logic [CW-1:0] term_cnt;
    logic          ovf_cnt;

    int checks = 0;
    int errors = 0;

    j_mac_accum #(.MAXTERMS(MAXTERMS), .CW(CW)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .clr       (clr),
        .mac_valid (mac_valid),
        .mac_ready (mac_ready),
        .prod      (prod),
        .sub       (sub),
        .res_req   (res_req),
        .res_valid (res_valid),
        .accum_lo  (accum_lo),
        .accum_hi  (accum_hi),
        .term_cnt  (term_cnt),
        .ovf_cnt   (ovf_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // One comparison: count it, and on mismatch count the failure and report.
    task automatic checkOutput(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs from a falling edge, leaving us at the next
    // falling edge with the post-clock state visible.
    task automatic applyStimulus(input logic v, input logic [31:0] p, input logic s,
                                 input logic rq, input logic c);
        mac_valid = v;
        prod      = p;
        sub       = s;
        res_req   = rq;
        clr       = c;
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Idle until the result pulse appears, with a bounded cycle budget.
    task automatic waitResult(input string tag);
        int n = 0;
        while (res_valid !== 1'b1 && n < 8) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checkOutput({tag, "_res_valid"}, 40'(res_valid), 40'd1);
    endtask

    initial begin
        reset = 1'b1;
        clr = 1'b0; mac_valid = 1'b0; prod = '0; sub = 1'b0; res_req = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;

        // Reset state
        checkOutput("rst_lo",    40'(accum_lo),  40'h0);
        checkOutput("rst_hi",    40'(accum_hi),  40'h0);
        checkOutput("rst_term",  40'(term_cnt),  40'h0);
        checkOutput("rst_ovf",   40'(ovf_cnt),   40'h0);
        checkOutput("rst_rv",    40'(res_valid), 40'h0);
        checkOutput("rst_ready", 40'(mac_ready), 40'h1);

        // 3 + 4 = 7
        applyStimulus(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_drain_ready", 40'(mac_ready), 40'h0);
        waitResult("t1");
        checkOutput("t1_lo",   40'(accum_lo), 40'h7);
        checkOutput("t1_hi",   40'(accum_hi), 40'h0);
        checkOutput("t1_term", 40'(term_cnt), 40'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_pulse_end", 40'(res_valid), 40'h0);

        // clr then subtract 5 -> -5
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_clr_lo", 40'(accum_lo), 40'h0);
        applyStimulus(1'b1, 32'h5, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        waitResult("t2");
        checkOutput("t2_lo", 40'(accum_lo), 40'hFFFF_FFFB);
        checkOutput("t2_hi", 40'(accum_hi), 40'hFF);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // 4 x 0x7FFFFFFF = 0x1_FFFF_FFFC carries into guard bits
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        waitResult("t3");
        checkOutput("t3_lo",   40'(accum_lo), 40'hFFFF_FFFC);
        checkOutput("t3_hi",   40'(accum_hi), 40'h01);
        checkOutput("t3_term", 40'(term_cnt), 40'd4);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // MAXTERMS accepts fill the count, one more sets the sticky flag
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < MAXTERMS; i++) applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_full_term", 40'(term_cnt), 40'd16);
        checkOutput("t4_full_ovf",  40'(ovf_cnt),  40'h0);
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_term", 40'(term_cnt), 40'd16);
        checkOutput("t4_ovf",  40'(ovf_cnt),  40'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_clr_term", 40'(term_cnt), 40'h0);
        checkOutput("t4_clr_ovf",  40'(ovf_cnt),  40'h0);
        checkOutput("t4_clr_lo",   40'(accum_lo), 40'h0);

        // res_req with accept of 0x10; product offered in DRAIN is refused
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_drain_ready", 40'(mac_ready), 40'h0);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_drain_ready2", 40'(mac_ready), 40'h0);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_rv",    40'(res_valid), 40'h1);
        checkOutput("t5_ready", 40'(mac_ready), 40'h0);
        checkOutput("t5_lo",    40'(accum_lo),  40'h10);
        checkOutput("t5_term",  40'(term_cnt),  40'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_idle_ready", 40'(mac_ready), 40'h1);
        checkOutput("t5_after_lo",   40'(accum_lo),  40'h10);

        // Reset while in DRAIN clears everything at once
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_in_drain", 40'(mac_ready), 40'h0);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_lo",    40'(accum_lo),  40'h0);
        checkOutput("t6_rst_term",  40'(term_cnt),  40'h0);
        checkOutput("t6_rst_rv",    40'(res_valid), 40'h0);
        checkOutput("t6_rst_ready", 40'(mac_ready), 40'h1);
        @(negedge sys_clk);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_no_rv", 40'(res_valid), 40'h0);

        // clr with accept of 0x2 -> result 0x2
        applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        waitResult("t6");
        checkOutput("t6_lo", 40'(accum_lo), 40'h2);
        checkOutput("t6_hi", 40'(accum_hi), 40'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // res_req from IDLE pulses the held accumulator directly
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("t7_rv", 40'(res_valid), 40'h1);
        checkOutput("t7_lo", 40'(accum_lo),  40'h2);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t7_rv_end", 40'(res_valid), 40'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
